osd_window: RTL and testbench
=============================

Name: osd_window

Overview:
- Next-generation on-screen-display mixer: a runtime-programmable rectangular window overlaid on a pixel stream.
- Window position and mix mode are programmable and take effect only at frame boundaries, so changes never tear mid-frame.
- Channel width and coordinate width are parametrised. Four mix modes are provided, plus an optional colour key.
- Sits between the video timing/frame source and the HDMI/VGA encoder. It supplies window-relative coordinates to an OSD pixel source, such as a char-ROM or framebuffer with 1-cycle read latency.

Parameters:
- C_bits, 8, bits per colour channel
- C_coord_bits, 10, width of all x/y counters and coordinates
- C_x_start, 128, reset value of shadow x_start
- C_x_stop, 383, reset value of shadow x_stop
- C_y_start, 128, reset value of shadow y_start
- C_y_stop, 383, reset value of shadow y_stop
- C_mode, 0, reset value of shadow mode
- C_key_en, 0, 1 = enable colour-key transparency

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- clk_pixel_ena  in  1  pixel enable; all state advances only when 1 (reset acts regardless)
- i_r, i_g, i_b  in  C_bits each  background video
- i_hsync, i_vsync, i_blank  in  1 each  background timing, active-high
- i_x_start, i_x_stop, i_y_start, i_y_stop  in  C_coord_bits each  requested window bounds, inclusive
- i_mode  in  2  requested mix mode
- i_alpha  in  4  OSD weight for mode 3
- i_key  in  3*C_bits  colour key {r,g,b}
- i_osd_en  in  1  global OSD enable, sampled with the OSD pixel
- i_osd_r, i_osd_g, i_osd_b  in  C_bits each  OSD pixel, returned 1 enabled cycle after coordinates
- o_osd_x, o_osd_y  out  C_coord_bits each  window-relative coordinate request
- o_osd_in  out  1  request is inside the window
- o_r, o_g, o_b  out  C_bits each  mixed video
- o_hsync, o_vsync, o_blank  out  1 each  timing delayed to match video

Behaviour:
Reset:
- Counters, coordinates, o_osd_in, RGB and syncs go to 0; o_blank goes to 1.
- Shadow registers load the C_* parameter values.
- A frame_valid flag clears. While it is 0, o_osd_in is forced to 0.
- frame_valid sets on the first enabled cycle with i_vsync=1. Reset mid-frame therefore shows no OSD until the next vsync.

Counters (enabled cycles only):
- xcount = number of unblanked pixels since the last hsync rising edge. It clears on the rising edge; each cycle with i_blank=0 uses the current value, then increments. It wraps modulo 2^C_coord_bits.
- line_seen sets on any unblanked pixel and clears at each hsync rising edge.
- ycount increments at an hsync rising edge only if line_seen=1. It holds 0 while i_vsync=1.

Shadowing:
- On the i_vsync rising edge, shadows load i_x_start, i_x_stop, i_y_start, i_y_stop, i_mode and i_alpha.
- i_key is used live.

Window test, for pixel P at enabled cycle n:
- in = !i_blank & frame_valid & (x_start ≤ xcount ≤ x_stop) & (y_start ≤ ycount ≤ y_stop), using shadow values.
- If start > stop on either axis, in=0 everywhere.

Stage 1 (registered at end of cycle n):
- o_osd_in = in.
- o_osd_x = xcount − x_start and o_osd_y = ycount − y_start, truncated to C_coord_bits.
- Coordinates hold their last value when in=0.
- Video and syncs are delayed into an internal stage.

Stage 2 (cycle n+1):
- i_osd_* holds P's OSD pixel.
- Keyed = C_key_en & ({i_osd_r,i_osd_g,i_osd_b} == i_key).
- If stage-1 in & i_osd_en & !keyed, the mixed value is applied; otherwise video passes unchanged.
- Results are registered at end of n+1. Total video/sync latency is exactly 2 enabled cycles.

Mix modes, per channel (o = OSD value, v = video value):
- Mode 0, opaque: o.
- Mode 1, OR-transparency: {o[msb], o[msb-1:0] | v[msb:1]}.
- Mode 2, 50% blend: (o+v)>>1, computed at C_bits+1 width with no overflow.
- Mode 3, alpha blend: (o·a + v·(16−a))>>4, where a = i_alpha.
  - a=0 gives video.
  - a=15 gives 15/16 OSD.
  - Intermediate width is C_bits+5; the result truncates and never exceeds 2^C_bits−1.

Enable gating:
- clk_pixel_ena=0 freezes all registers, including both pipeline stages.

Simultaneous events:
- hsync rising edge coinciding with an unblanked pixel: the clear takes priority, so that pixel is counted as x=0 of the new line.
- vsync rising edge coinciding with input changes: the new shadow values apply to the next frame.

Test Plan:
- Reset, then 640x480 timing, defaults, mode 0, OSD source returns 8'hFF white:
  - Frame 1 has no OSD.
  - From frame 2, output pixels (128..383, 128..383) are white, all others equal video.
  - Latency is 2 enabled cycles and syncs are aligned.
- i_x_start=10, i_x_stop=19 written mid-frame:
  - The current frame still uses 128..383.
  - The next frame shows OSD at x 10..19.
  - o_osd_x runs 0..9 on every window line.
- Video 8'h80, OSD 8'hFF, all channels:
  - Mode 1 → 8'hFF.
  - Mode 2 → 8'hBF.
  - Mode 3 with a=4 → 8'h9F.
  - Mode 3 with a=0 → 8'h80.
- C_key_en=1, i_key=24'h000000, OSD returns black inside the window → output equals video. Setting i_osd_en=0 also gives output equal to video.
- clk_pixel_ena toggling 1-in-3 → outputs identical to the full-rate run, sampled at enabled cycles. Setting x_start=50, x_stop=40 → o_osd_in is never 1.
- Reset asserted mid-window for 1 cycle:
  - o_blank goes to 1 and RGB to 0 on the next cycle.
  - There is no OSD until after the next vsync.
  - Shadows revert to 128/383.

Source files
------------

// File: rtl/osd_window.sv
// Rectangular OSD window mixer: frame-locked window/mode shadows, window-relative
// coordinate request (stage 1), four-mode per-channel mix with optional colour key (stage 2).
module osd_window #(
  parameter int C_bits       = 8,
  parameter int C_coord_bits = 10,
  parameter int C_x_start    = 128,
  parameter int C_x_stop     = 383,
  parameter int C_y_start    = 128,
  parameter int C_y_stop     = 383,
  parameter int C_mode       = 0,
  parameter int C_key_en     = 0
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic                      clk_pixel_ena,
  input  logic [C_bits-1:0]         i_r,
  input  logic [C_bits-1:0]         i_g,
  input  logic [C_bits-1:0]         i_b,
  input  logic                      i_hsync,
  input  logic                      i_vsync,
  input  logic                      i_blank,
  input  logic [C_coord_bits-1:0]   i_x_start,
  input  logic [C_coord_bits-1:0]   i_x_stop,
  input  logic [C_coord_bits-1:0]   i_y_start,
  input  logic [C_coord_bits-1:0]   i_y_stop,
  input  logic [1:0]                i_mode,
  input  logic [3:0]                i_alpha,
  input  logic [3*C_bits-1:0]       i_key,
  input  logic                      i_osd_en,
  input  logic [C_bits-1:0]         i_osd_r,
  input  logic [C_bits-1:0]         i_osd_g,
  input  logic [C_bits-1:0]         i_osd_b,
  output logic [C_coord_bits-1:0]   o_osd_x,
  output logic [C_coord_bits-1:0]   o_osd_y,
  output logic                      o_osd_in,
  output logic [C_bits-1:0]         o_r,
  output logic [C_bits-1:0]         o_g,
  output logic [C_bits-1:0]         o_b,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_blank
);

  localparam int CB = C_bits;
  localparam int CW = C_coord_bits;
  localparam int PW = 3 * C_bits;

  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [CW-1:0] xcount_q, xcount_d, ycount_q, ycount_d;
  logic          line_seen_q, line_seen_d, frame_valid_q, frame_valid_d;
  logic [CW-1:0] x_start_q, x_start_d, x_stop_q, x_stop_d;
  logic [CW-1:0] y_start_q, y_start_d, y_stop_q, y_stop_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    alpha_q, alpha_d;
  logic          osd_in_q, osd_in_d;
  logic [CW-1:0] osd_x_q, osd_x_d, osd_y_q, osd_y_d;
  logic [PW-1:0] s1_rgb_q, s1_rgb_d;
  logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_blank_q, s1_blank_d;
  logic [PW-1:0] out_rgb_q, out_rgb_d;
  logic          out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_blank_q, out_blank_d;

  logic          hs_rise, vs_rise, win_in, keyed, apply;
  logic [CW-1:0] cur_x, cur_y;
  logic [PW-1:0] osd_pix, mix_rgb;

  always_comb begin : p_stage1
    hs_rise = i_hsync & ~hs_prev_q;
    vs_rise = i_vsync & ~vs_prev_q;
    // An unblanked pixel on the hsync rising edge already belongs to the new line.
    cur_x   = hs_rise ? '0 : xcount_q;
    if (i_vsync)
      cur_y = '0;
    else if (hs_rise && line_seen_q)
      cur_y = ycount_q + CW'(1);
    else
      cur_y = ycount_q;

    win_in = ~i_blank & frame_valid_q
           & (cur_x >= x_start_q) & (cur_x <= x_stop_q)
           & (cur_y >= y_start_q) & (cur_y <= y_stop_q);

    xcount_d      = i_blank ? cur_x : cur_x + CW'(1);
    ycount_d      = cur_y;
    line_seen_d   = (line_seen_q & ~hs_rise) | ~i_blank;
    frame_valid_d = frame_valid_q | i_vsync;
    hs_prev_d     = i_hsync;
    vs_prev_d     = i_vsync;

    x_start_d = x_start_q;
    x_stop_d  = x_stop_q;
    y_start_d = y_start_q;
    y_stop_d  = y_stop_q;
    mode_d    = mode_q;
    alpha_d   = alpha_q;
    if (vs_rise) begin
      x_start_d = i_x_start;
      x_stop_d  = i_x_stop;
      y_start_d = i_y_start;
      y_stop_d  = i_y_stop;
      mode_d    = i_mode;
      alpha_d   = i_alpha;
    end

    osd_in_d   = win_in;
    osd_x_d    = win_in ? cur_x - x_start_q : osd_x_q;
    osd_y_d    = win_in ? cur_y - y_start_q : osd_y_q;
    s1_rgb_d   = {i_r, i_g, i_b};
    s1_hs_d    = i_hsync;
    s1_vs_d    = i_vsync;
    s1_blank_d = i_blank;
  end

  assign osd_pix = {i_osd_r, i_osd_g, i_osd_b};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [CB-1:0] o_v, v_v, mix;
      logic [CB:0]   sum2;
      logic [CB+4:0] o_w, v_w, a_w, inv_w, sum3;

      always_comb begin
        o_v   = osd_pix[gi*CB +: CB];
        v_v   = s1_rgb_q[gi*CB +: CB];
        sum2  = {1'b0, o_v} + {1'b0, v_v};
        o_w   = {5'b0, o_v};
        v_w   = {5'b0, v_v};
        a_w   = {{(CB+1){1'b0}}, alpha_q};
        inv_w = (CB+5)'(16) - a_w;
        sum3  = o_w * a_w + v_w * inv_w;
        mix   = o_v;
        case (mode_q)
          2'd0: mix = o_v;
          2'd1: mix = {o_v[CB-1], o_v[CB-2:0] | v_v[CB-1:1]};
          2'd2: mix = sum2[CB:1];
          2'd3: mix = sum3[CB+3:4];
          default: mix = o_v;
        endcase
      end

      assign mix_rgb[gi*CB +: CB] = mix;
    end
  endgenerate

  always_comb begin : p_stage2
    keyed       = (C_key_en != 0) && (osd_pix == i_key);
    apply       = osd_in_q & i_osd_en & ~keyed;
    out_rgb_d   = apply ? mix_rgb : s1_rgb_q;
    out_hs_d    = s1_hs_q;
    out_vs_d    = s1_vs_q;
    out_blank_d = s1_blank_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      xcount_q      <= '0;
      ycount_q      <= '0;
      line_seen_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      x_start_q     <= CW'(C_x_start);
      x_stop_q      <= CW'(C_x_stop);
      y_start_q     <= CW'(C_y_start);
      y_stop_q      <= CW'(C_y_stop);
      mode_q        <= 2'(C_mode);
      alpha_q       <= 4'd0;
      osd_in_q      <= 1'b0;
      osd_x_q       <= '0;
      osd_y_q       <= '0;
      s1_rgb_q      <= '0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_blank_q    <= 1'b1;
      out_rgb_q     <= '0;
      out_hs_q      <= 1'b0;
      out_vs_q      <= 1'b0;
      out_blank_q   <= 1'b1;
    end else if (clk_pixel_ena) begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      xcount_q      <= xcount_d;
      ycount_q      <= ycount_d;
      line_seen_q   <= line_seen_d;
      frame_valid_q <= frame_valid_d;
      x_start_q     <= x_start_d;
      x_stop_q      <= x_stop_d;
      y_start_q     <= y_start_d;
      y_stop_q      <= y_stop_d;
      mode_q        <= mode_d;
      alpha_q       <= alpha_d;
      osd_in_q      <= osd_in_d;
      osd_x_q       <= osd_x_d;
      osd_y_q       <= osd_y_d;
      s1_rgb_q      <= s1_rgb_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_blank_q    <= s1_blank_d;
      out_rgb_q     <= out_rgb_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
      out_blank_q   <= out_blank_d;
    end
  end

  assign o_osd_in = osd_in_q;
  assign o_osd_x  = osd_x_q;
  assign o_osd_y  = osd_y_q;
  assign o_r      = out_rgb_q[2*CB +: CB];
  assign o_g      = out_rgb_q[CB +: CB];
  assign o_b      = out_rgb_q[0 +: CB];
  assign o_hsync  = out_hs_q;
  assign o_vsync  = out_vs_q;
  assign o_blank  = out_blank_q;

endmodule

// File: tb/tb_osd_window.sv
// Directed bench for osd_window on a reduced raster: frames of 24x10 active pixels,
// expected output derived from pixel geometry and hand-computed mix values.
module tb_osd_window;

  localparam int XS = 4, XE = 11, YS = 2, YE = 5;
  localparam int W = 24, LINE = 31, V_ACT = 10, V_TOT = 14;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
  } exp_t;

  localparam exp_t RST_EXP = {24'h000000, 1'b0, 1'b0, 1'b1};

  logic       clk_pixel = 1'b0;
  logic       reset, clk_pixel_ena;
  logic [7:0] i_r, i_g, i_b;
  logic       i_hsync, i_vsync, i_blank;
  logic [9:0] req_xs, req_xe, req_ys, req_ye;
  logic [1:0] req_mode;
  logic [3:0] req_alpha;
  logic [23:0] key;
  logic       osd_en;
  logic [7:0] osd_col;
  logic [9:0] o_osd_x, o_osd_y;
  logic       o_osd_in;
  logic [7:0] o_r, o_g, o_b;
  logic       o_hsync, o_vsync, o_blank;

  always #5 clk_pixel = ~clk_pixel;

  osd_window #(
    .C_bits(8), .C_coord_bits(10),
    .C_x_start(XS), .C_x_stop(XE), .C_y_start(YS), .C_y_stop(YE),
    .C_mode(0), .C_key_en(1)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(clk_pixel_ena),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
    .i_x_start(req_xs), .i_x_stop(req_xe), .i_y_start(req_ys), .i_y_stop(req_ye),
    .i_mode(req_mode), .i_alpha(req_alpha), .i_key(key), .i_osd_en(osd_en),
    .i_osd_r(osd_col), .i_osd_g(osd_col), .i_osd_b(osd_col),
    .o_osd_x(o_osd_x), .o_osd_y(o_osd_y), .o_osd_in(o_osd_in),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_cnt  = 0;
  int   rst_line = -1;
  int   rst_pix  = -1;
  logic vid_const = 1'b0;

  // Expected-state model: shadowed window/mode, two-entry output history.
  int         win_xs = XS, win_xe = XE, win_ys = YS, win_ye = YE;
  logic [1:0] mode_cur = 2'd0;
  logic [7:0] mix_cur  = 8'h00;
  logic [7:0] mix_next = 8'h00;
  logic       fv_e = 1'b0, vs_prev_e = 1'b0, osd_in_e = 1'b0;
  int         exp_x = 0, exp_y = 0;
  exp_t       prev_e = RST_EXP;
  exp_t       out_e  = RST_EXP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
  endtask

  task automatic cyc(input logic ena, input logic rst, input logic blank,
                     input logic hs, input logic vs, input int x, input int y);
    logic [23:0] vid;
    logic [7:0]  c8, mixv;
    logic        in_e, apply;
    exp_t        cur;
    c8  = cyc_cnt[7:0];
    vid = vid_const ? 24'h808080 : {c8, c8 ^ 8'h5A, ~c8};
    reset = rst;
    clk_pixel_ena = ena;
    i_blank = blank;
    i_hsync = hs;
    i_vsync = vs;
    {i_r, i_g, i_b} = vid;

    in_e  = !blank && fv_e && x >= win_xs && x <= win_xe && y >= win_ys && y <= win_ye;
    apply = in_e && osd_en && ({3{osd_col}} != key);
    mixv  = (mode_cur == 2'd0) ? osd_col : mix_cur;
    cur.rgb   = apply ? {3{mixv}} : vid;
    cur.hs    = hs;
    cur.vs    = vs;
    cur.blank = blank;

    @(posedge clk_pixel);
    #1;
    if (rst) begin
      out_e = RST_EXP;  prev_e = RST_EXP;
      fv_e = 1'b0;  vs_prev_e = 1'b0;  osd_in_e = 1'b0;
      exp_x = 0;  exp_y = 0;
      win_xs = XS;  win_xe = XE;  win_ys = YS;  win_ye = YE;
      mode_cur = 2'd0;
    end else if (ena) begin
      out_e  = prev_e;
      prev_e = cur;
      osd_in_e = in_e;
      if (in_e) begin
        exp_x = x - win_xs;
        exp_y = y - win_ys;
      end
      if (vs && !vs_prev_e) begin
        win_xs = int'(req_xs);  win_xe = int'(req_xe);
        win_ys = int'(req_ys);  win_ye = int'(req_ye);
        mode_cur = req_mode;
        mix_cur  = mix_next;
      end
      if (vs) fv_e = 1'b1;
      vs_prev_e = vs;
    end
    check("rgb",    {8'h0, o_r, o_g, o_b}, {8'h0, out_e.rgb});
    check("sync",   {29'h0, o_hsync, o_vsync, o_blank}, {29'h0, out_e.hs, out_e.vs, out_e.blank});
    check("osd_in", {31'h0, o_osd_in}, {31'h0, osd_in_e});
    check("osd_xy", {12'h0, o_osd_x, o_osd_y}, {12'h0, exp_x[9:0], exp_y[9:0]});
    cyc_cnt++;
  endtask

  task automatic frame(input string name, input int div);
    int pass0;
    pass0 = n_checks - n_pass;
    for (int ln = 0; ln < V_TOT; ln++) begin
      for (int p = 0; p < LINE; p++) begin
        logic bl, hs, vs, rs;
        bl = !(ln < V_ACT && p < W);
        hs = (p >= W + 2) && (p <= W + 4);
        vs = (ln == V_ACT + 1) || (ln == V_ACT + 2);
        rs = (ln == rst_line) && (p == rst_pix);
        for (int k = 1; k < div; k++) cyc(1'b0, 1'b0, bl, hs, vs, p, ln);
        cyc(1'b1, rs, bl, hs, vs, p, ln);
      end
    end
    $display("frame %-18s win=%0d..%0d,%0d..%0d mode=%0d checks=%0d new_errors=%0d",
             name, win_xs, win_xe, win_ys, win_ye, mode_cur, n_checks,
             (n_checks - n_pass) - pass0);
  endtask

  initial begin
    req_xs = 10'(XS);  req_xe = 10'(XE);  req_ys = 10'(YS);  req_ye = 10'(YE);
    req_mode = 2'd0;  req_alpha = 4'd0;
    key = 24'h123456;  osd_en = 1'b1;  osd_col = 8'hFF;
    reset = 1'b1;  clk_pixel_ena = 1'b0;
    i_r = 8'h0;  i_g = 8'h0;  i_b = 8'h0;
    i_hsync = 1'b0;  i_vsync = 1'b0;  i_blank = 1'b1;

    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check("reset_blank", {31'h0, o_blank}, 32'd1);
    check("reset_rgb",   {8'h0, o_r, o_g, o_b}, 32'd0);

    frame("no_osd_first", 1);
    frame("default_window", 1);

    req_xs = 10'd10;  req_xe = 10'd19;
    frame("x_written_mid", 1);
    frame("x_10_19", 1);

    vid_const = 1'b1;
    req_mode = 2'd1;  mix_next = 8'hFF;
    frame("mode1_latch", 1);
    req_mode = 2'd2;  mix_next = 8'hBF;
    frame("mode1_or", 1);
    req_mode = 2'd3;  req_alpha = 4'd4;  mix_next = 8'h9F;
    frame("mode2_blend", 1);
    req_alpha = 4'd0;  mix_next = 8'h80;
    frame("mode3_a4", 1);
    req_mode = 2'd0;
    frame("mode3_a0", 1);
    vid_const = 1'b0;

    osd_col = 8'h00;  key = 24'h000000;
    frame("key_black", 1);
    key = 24'h123456;
    frame("unkeyed_black", 1);
    osd_col = 8'hFF;  osd_en = 1'b0;
    frame("osd_disabled", 1);
    osd_en = 1'b1;

    frame("ena_1_in_3", 3);

    req_xs = 10'd50;  req_xe = 10'd40;
    frame("x_inverted_latch", 1);
    req_xs = 10'(XS);  req_xe = 10'(XE);
    frame("x_inverted", 1);

    rst_line = 3;  rst_pix = 6;
    frame("reset_mid_window", 1);
    rst_line = -1;  rst_pix = -1;
    frame("after_reset", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
